// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo: Philips I2S stereo transmitter, 32-bit slots, one-entry holding register, BCK/LRCK derived from clk
module i2s_tx_stereo #(
   parameter int BCK_DIV = 16,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] left_i,
   input  logic [WIDTH-1:0] right_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             bck_o,
   output logic             lrck_o,
   output logic             sd_o,
   output logic             frame_o,
   output logic             underrun_o
);
   localparam int DW = $clog2(BCK_DIV);
   logic [DW-1:0] div_q, div_d;
   logic [5:0] bit_q, bit_d;
   logic [63:0] sh_q, sh_d, new_frame;
   logic [WIDTH-1:0] hl_q, hl_d, hr_q, hr_d;
   logic [31:0] slot_l, slot_r;
   logic full_q, full_d, bck_q, bck_d, lrck_q, lrck_d, sd_q, sd_d, frame_q, un_q;
   logic fall, load, cap;
   // a load with the register empty sends silence; a same-edge capture waits for the next frame
   always_comb begin
      fall = div_q == DW'(BCK_DIV - 1);
      div_d = fall ? '0 : div_q + 1'b1;
      bck_d = div_d >= DW'(BCK_DIV / 2);
      bit_d = fall ? bit_q + 1'b1 : bit_q;
      load = fall && bit_q == 6'd63;
      cap = valid_i && !full_q;
      full_d = cap | (full_q & ~load);
      hl_d = cap ? left_i : hl_q;
      hr_d = cap ? right_i : hr_q;
      slot_l = 32'(hl_q) << (31 - WIDTH);
      slot_r = 32'(hr_q) << (31 - WIDTH);
      new_frame = full_q ? {slot_l, slot_r} : '0;
      sh_d = load ? {new_frame[62:0], 1'b0} : fall ? {sh_q[62:0], 1'b0} : sh_q;
      sd_d = load ? new_frame[63] : fall ? sh_q[63] : sd_q;
      lrck_d = fall ? bit_d[5] : lrck_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         div_q <= '0;
         bit_q <= 6'd63;
         sh_q <= '0;
         hl_q <= '0;
         hr_q <= '0;
         full_q <= 1'b0;
         bck_q <= 1'b0;
         lrck_q <= 1'b0;
         sd_q <= 1'b0;
         frame_q <= 1'b0;
         un_q <= 1'b0;
      end else begin
         div_q <= div_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         hl_q <= hl_d;
         hr_q <= hr_d;
         full_q <= full_d;
         bck_q <= bck_d;
         lrck_q <= lrck_d;
         sd_q <= sd_d;
         frame_q <= load;
         un_q <= load & ~full_q;
      end
   assign ready_o = !full_q;
   assign bck_o = bck_q;
   assign lrck_o = lrck_q;
   assign sd_o = sd_q;
   assign frame_o = frame_q;
   assign underrun_o = un_q;
endmodule

// File: tb/tb_i2s_tx_stereo.sv
// tb_i2s_tx_stereo: scoreboard bench for i2s_tx_stereo at default and small parameters
module tb_i2s_tx_stereo;
   logic clk = 0, reset = 1;
   logic [23:0] l1 = 0, r1 = 0;
   logic valid1 = 0, ready_o, bck_o, lrck_o, sd_o, frame_o, underrun_o;
   logic [15:0] l2 = 0, r2 = 0;
   logic valid2 = 0, ready2, bck2, lrck2, sd2, fr2, un2;
   int checks = 0, failures = 0, cyc = 0, done = 0;
   logic [63:0] exp_fr[$];
   logic exp_un[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   i2s_tx_stereo #(.BCK_DIV(16), .WIDTH(24)) dut (
      .clk(clk), .reset(reset), .left_i(l1), .right_i(r1), .valid_i(valid1), .ready_o(ready_o),
      .bck_o(bck_o), .lrck_o(lrck_o), .sd_o(sd_o), .frame_o(frame_o), .underrun_o(underrun_o));
   i2s_tx_stereo #(.BCK_DIV(4), .WIDTH(16)) dut2 (
      .clk(clk), .reset(reset), .left_i(l2), .right_i(r2), .valid_i(valid2), .ready_o(ready2),
      .bck_o(bck2), .lrck_o(lrck2), .sd_o(sd2), .frame_o(fr2), .underrun_o(un2));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] mk(input logic [31:0] l, input logic [31:0] r, input int wd);
      logic [63:0] f;
      f = '0;
      for (int k = 1; k <= wd; k++) begin
         f[63-k] = l[wd-k];
         f[31-k] = r[wd-k];
      end
      return f;
   endfunction
   task automatic push(input logic [63:0] f, input logic u);
      exp_fr.push_back(f);
      exp_un.push_back(u);
   endtask
   task automatic chk_rst();
      chk("rst_bck", bck_o, 0);
      chk("rst_lrck", lrck_o, 0);
      chk("rst_sd", sd_o, 0);
      chk("rst_ready", ready_o, 1);
      chk("rst_frame", frame_o, 0);
      chk("rst_underrun", underrun_o, 0);
   endtask
   task automatic wait_fr(input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!frame_o && t < 2000);
         if (!frame_o) chk("frame_timeout", 0, 1);
      end
   endtask
   // monitor: each frame_o pops one expected frame, then collects 64 bits on BCK rising edges
   initial begin
      logic [63:0] w, wl, cur;
      logic act, prev, have_last;
      int n, last;
      act = 0; prev = 0; have_last = 0; n = 0; last = 0; w = 0; wl = 0; cur = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            act = 0;
            prev = 0;
            have_last = 0;
         end else begin
            if (underrun_o && !frame_o) chk("underrun_stray", 1, 0);
            if (frame_o) begin
               if (have_last) chk("frame_period", 64'(cyc - last), 64'(64 * 16));
               last = cyc;
               have_last = 1;
               if (exp_fr.size() == 0) chk("sb_empty", 0, 1);
               else begin
                  cur = exp_fr.pop_front();
                  chk("underrun", underrun_o, exp_un.pop_front());
                  act = 1; n = 0; w = 0; wl = 0;
               end
            end
            if (act && bck_o && !prev) begin
               w = {w[62:0], sd_o};
               wl = {wl[62:0], lrck_o};
               n++;
               if (n == 64) begin
                  chk("frame_data", w, cur);
                  chk("frame_lrck", wl, 64'h0000_0000_FFFF_FFFF);
                  act = 0;
                  done++;
               end
            end
            prev = bck_o;
         end
      end
   end
   initial begin
      int t, n, lastr, per;
      logic prev, flag;
      logic [63:0] w2, wl2;
      repeat (3) @(negedge clk);
      chk_rst();
      reset = 0;
      // single pair offered at cycle 2, carried in frame 1; then starvation
      @(negedge clk);
      @(negedge clk);
      l1 = 24'hA5A5A5; r1 = 24'h123456; valid1 = 1;
      push(mk(32'hA5A5A5, 32'h123456, 24), 0);
      @(negedge clk);
      valid1 = 0;
      chk("ready_drop", ready_o, 0);
      repeat (3) push(64'h0, 1);
      wait_fr(4);
      // back-to-back: B1 captured at once, B2 waits for the frame-5 load
      l1 = 24'h800001; r1 = 24'h7FFFFF; valid1 = 1;
      push(mk(32'h800001, 32'h7FFFFF, 24), 0);
      push(mk(32'h000001, 32'hFFFFFF, 24), 0);
      @(negedge clk);
      l1 = 24'h000001; r1 = 24'hFFFFFF;
      chk("ready_b1", ready_o, 0);
      repeat (100) @(negedge clk);
      chk("ready_hold", ready_o, 0);
      t = 0;
      while (!ready_o && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("ready_return", ready_o, 1);
      @(negedge clk);
      valid1 = 0;
      chk("ready_b2", ready_o, 0);
      wait_fr(1);
      // boundary race: valid only on the frame-7 load edge
      push(64'h0, 1);
      push(mk(32'h5A5A5A, 32'hC3C3C3, 24), 0);
      repeat (1023) @(negedge clk);
      chk("ready_pre_race", ready_o, 1);
      l1 = 24'h5A5A5A; r1 = 24'hC3C3C3; valid1 = 1;
      @(negedge clk);
      valid1 = 0;
      chk("ready_race", ready_o, 0);
      wait_fr(1);
      // frame 9 is in flight and E buffered when reset hits mid-frame
      l1 = 24'hABCDEF; r1 = 24'hFEDCBA; valid1 = 1;
      push(mk(32'hABCDEF, 32'hFEDCBA, 24), 0);
      @(negedge clk);
      valid1 = 0;
      wait_fr(1);
      l1 = 24'h111111; r1 = 24'h222222; valid1 = 1;
      @(negedge clk);
      valid1 = 0;
      repeat (600) @(negedge clk);
      chk("ready_full", ready_o, 0);
      chk("lrck_right", lrck_o, 1);
      #2 reset = 1;
      #1 chk_rst();
      push(64'h0, 1);
      repeat (5) @(negedge clk);
      reset = 0;
      flag = 0;
      repeat (15) begin
         @(negedge clk);
         if (frame_o) flag = 1;
      end
      chk("no_early_frame", flag, 0);
      @(negedge clk);
      chk("first_frame", frame_o, 1);
      // parameter sweep: BCK_DIV=4, WIDTH=16
      chk("sw_ready", ready2, 1);
      l2 = 16'h8001; r2 = 16'h00FF; valid2 = 1;
      @(negedge clk);
      valid2 = 0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(fr2 && !un2) && t < 1000);
      chk("sw_load", fr2 && !un2, 1);
      prev = bck2; n = 0; t = 0; lastr = -1; per = 4; w2 = 0; wl2 = 0;
      while (n < 64 && t < 600) begin
         @(negedge clk);
         t++;
         if (bck2 && !prev) begin
            w2 = {w2[62:0], sd2};
            wl2 = {wl2[62:0], lrck2};
            if (lastr >= 0 && cyc - lastr != 4) per = cyc - lastr;
            lastr = cyc;
            n++;
         end
         prev = bck2;
      end
      chk("sw_bits", n, 64);
      chk("sw_bck_period", per, 4);
      chk("sw_frame", w2, mk(32'h8001, 32'h00FF, 16));
      chk("sw_lrck", wl2, 64'h0000_0000_FFFF_FFFF);
      t = 0;
      while (done < 9 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("sb_done", done, 9);
      chk("sb_left", exp_fr.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
